wb_ram_slave: RTL and testbench

Wishbone responder that backs a word-addressed on-chip RAM and answers single-word read and write cycles from masters such as the core's load and store units. It sits behind the Wishbone interconnect on the `wb_bus_t` slave side. It latches each request, inserts a programmable number of wait states, and returns one acknowledge pulse per access.

---
 rtl/wb_ram_slave_if.sv | 23 ++
 rtl/wb_ram_slave.sv | 106 ++++++++++
 tb/tb_wb_ram_slave.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_ram_slave_if.sv
// Wishbone bus bundle shared by masters, the interconnect and RAM-backed responders.
interface wb_bus_t;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [31:0] wb_adr;
  logic [3:0]  wb_sel;
  logic [31:0] wb_dat_ms;
  logic [31:0] wb_dat_sm;
  logic        wb_ack;
  logic        wb_tgd_sm;
  logic        wb_gnt;

  modport slave (
    input  wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_dat_ms,
    output wb_ack, wb_dat_sm, wb_tgd_sm
  );

  modport master (
    output wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_dat_ms,
    input  wb_ack, wb_dat_sm, wb_tgd_sm, wb_gnt
  );
endinterface

// File: rtl/wb_ram_slave.sv
// Wishbone RAM responder: one outstanding single-word access, WAIT_CYCLES wait states, one ack per access.
// Optional macro WB_RAM_RANGE_CHECK_EN: out-of-range accesses are acked but read 0 and never write.
module wb_ram_slave #(
  parameter int unsigned DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input logic      clk,
  input logic      rstn_i,
  wb_bus_t.slave   wb_bus
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [3:0]  WAIT_LD = 4'(WAIT_CYCLES);
  localparam logic [32:0] SPAN    = 33'(DEPTH) * 33'd4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] ACK  = 2'd2;

  logic [1:0]    state;
  logic [3:0]    cnt;
  logic [31:0]   lat_adr;
  logic [31:0]   lat_dat;
  logic [3:0]    lat_sel;
  logic          lat_we;
  logic [31:0]   rd_dat_p1;
  logic [31:0]   mem [DEPTH];

  logic          req;
  logic          ack;
  logic          enter_ack;
  logic [31:0]   off;
  logic [AW-1:0] idx;
  logic          hit;
  logic          unused_off;

  assign req = wb_bus.wb_cyc && wb_bus.wb_stb;
  assign ack = (state == ACK) && req;

  // With zero wait states the read happens on the capture edge, before the latch holds the address.
  assign off        = ((state == IDLE) ? wb_bus.wb_adr : lat_adr) - BASE_ADDR;
  assign idx        = off[AW+1:2];
  assign unused_off = ^{off[31:AW+2], off[1:0]};

`ifdef WB_RAM_RANGE_CHECK_EN
  assign hit = ({1'b0, off} < SPAN);
`else
  assign hit = 1'b1;
`endif

  assign enter_ack = ((state == IDLE) && req && (WAIT_LD == 4'd0)) ||
                     ((state == BUSY) && wb_bus.wb_cyc && (cnt == 4'd1));

  assign wb_bus.wb_ack    = ack;
  assign wb_bus.wb_dat_sm = ack ? rd_dat_p1 : 32'h0000_0000;
  assign wb_bus.wb_tgd_sm = 1'b0;

  always_ff @(posedge clk) begin
    if (!rstn_i) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      rd_dat_p1 <= 32'h0000_0000;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            cnt   <= WAIT_LD;
            state <= (WAIT_LD == 4'd0) ? ACK : BUSY;
          end
        end
        BUSY: begin
          if (!wb_bus.wb_cyc) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) state <= ACK;
          end
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
      if (enter_ack) rd_dat_p1 <= hit ? mem[idx] : 32'h0000_0000;
    end
  end

  // ---- request capture: stage 0 ----
  always_ff @(posedge clk) begin
    if ((state == IDLE) && req) begin
      lat_adr <= wb_bus.wb_adr;
      lat_we  <= wb_bus.wb_we;
      lat_sel <= wb_bus.wb_sel;
      lat_dat <= wb_bus.wb_dat_ms;
    end
  end

  // ---- write commit on the edge leaving ACK; reset on that edge drops it ----
  always_ff @(posedge clk) begin
    if (rstn_i && ack && lat_we && hit) begin
      for (int i = 0; i < 4; i++) begin
        if (lat_sel[i]) mem[idx][8*i +: 8] <= lat_dat[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_wb_ram_slave.sv
// Scoreboard bench for wb_ram_slave with three instances: 0, 3 and 2 wait states, DEPTH=16.
module tb_wb_ram_slave;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [31:0] adr = '0, dat = '0;
  logic [3:0]  sel = '0;
  int          dsel = 0;

  logic        ack_o;
  logic [31:0] dat_o;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  wb_bus_t b0 ();
  wb_bus_t b1 ();
  wb_bus_t b2 ();

  assign b0.wb_cyc = cyc && (dsel == 0);
  assign b0.wb_stb = stb;
  assign b0.wb_we = we;
  assign b0.wb_adr = adr;
  assign b0.wb_sel = sel;
  assign b0.wb_dat_ms = dat;
  assign b0.wb_gnt = 1'b0;

  assign b1.wb_cyc = cyc && (dsel == 1);
  assign b1.wb_stb = stb;
  assign b1.wb_we = we;
  assign b1.wb_adr = adr;
  assign b1.wb_sel = sel;
  assign b1.wb_dat_ms = dat;
  assign b1.wb_gnt = 1'b0;

  assign b2.wb_cyc = cyc && (dsel == 2);
  assign b2.wb_stb = stb;
  assign b2.wb_we = we;
  assign b2.wb_adr = adr;
  assign b2.wb_sel = sel;
  assign b2.wb_dat_ms = dat;
  assign b2.wb_gnt = 1'b0;

  always_comb begin
    ack_o = b0.wb_ack;
    dat_o = b0.wb_dat_sm;
    if (dsel == 1) begin
      ack_o = b1.wb_ack;
      dat_o = b1.wb_dat_sm;
    end else if (dsel == 2) begin
      ack_o = b2.wb_ack;
      dat_o = b2.wb_dat_sm;
    end
  end

  wb_ram_slave #(.DEPTH(16), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) u_w0 (.clk(clk), .rstn_i(rstn), .wb_bus(b0));
  wb_ram_slave #(.DEPTH(16), .BASE_ADDR(32'h0), .WAIT_CYCLES(3)) u_w3 (.clk(clk), .rstn_i(rstn), .wb_bus(b1));
  wb_ram_slave #(.DEPTH(16), .BASE_ADDR(32'h0), .WAIT_CYCLES(2)) u_w2 (.clk(clk), .rstn_i(rstn), .wb_bus(b2));

  // Drives one access; lat = cycles from stb to ack (40 means no ack seen)
  task automatic do_access(input int d, input logic w, input logic [31:0] a, input logic [3:0] s,
                           input logic [31:0] wd, output int lat, output logic [31:0] rd);
    bit got;
    dsel = d;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat = wd;
    lat = 0; rd = '0; got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (ack_o) begin
        got = 1'b1;
        rd = dat_o;
      end else begin
        lat++;
      end
    end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    for (int d = 0; d < 3; d++) begin
      dsel = d;
      @(negedge clk);
      n_chk++;
      if ({ack_o, dat_o} !== 33'h0) begin
        n_err++;
        $display("FAIL reset_out dut%0d: got ack=%b dat=%h expected ack=0 dat=0", d, ack_o, dat_o);
      end
    end
  endtask

  task automatic test_full_word();
    int lat;
    logic [31:0] rd, e;
    do_access(0, 1'b1, 32'h8, 4'hF, 32'hA5A5_1234, lat, rd);
    n_chk++;
    if (lat !== 1) begin n_err++; $display("FAIL fw_wr_lat: got %0d expected 1", lat); end
    exp_q.push_back(32'hA5A5_1234);
    do_access(0, 1'b0, 32'h8, 4'hF, 32'h0, lat, rd);
    e = exp_q.pop_front();
    n_chk++;
    if (lat !== 1) begin n_err++; $display("FAIL fw_rd_lat: got %0d expected 1", lat); end
    n_chk++;
    if (rd !== e) begin n_err++; $display("FAIL fw_rd_data: got %h expected %h", rd, e); end
    exp_q.push_back(32'hA5A5_1234);
    do_access(0, 1'b0, 32'h8, 4'h0, 32'h0, lat, rd);
    e = exp_q.pop_front();
    n_chk++;
    if (rd !== e) begin n_err++; $display("FAIL fw_rd_sel0: got %h expected %h", rd, e); end
  endtask

  task automatic test_byte_lane();
    int lat;
    logic [31:0] rd, e;
    do_access(0, 1'b1, 32'h10, 4'hF, 32'h1122_3344, lat, rd);
    do_access(0, 1'b1, 32'h10, 4'b0010, 32'h0000_CD00, lat, rd);
    exp_q.push_back(32'h1122_CD44);
    do_access(0, 1'b0, 32'h10, 4'hF, 32'h0, lat, rd);
    e = exp_q.pop_front();
    n_chk++;
    if (rd !== e) begin n_err++; $display("FAIL byte_lane: got %h expected %h", rd, e); end
    do_access(0, 1'b1, 32'h10, 4'b0000, 32'hFFFF_FFFF, lat, rd);
    n_chk++;
    if (lat !== 1) begin n_err++; $display("FAIL sel0_ack_lat: got %0d expected 1", lat); end
    exp_q.push_back(32'h1122_CD44);
    do_access(0, 1'b0, 32'h13, 4'hF, 32'h0, lat, rd);
    e = exp_q.pop_front();
    n_chk++;
    if (rd !== e) begin n_err++; $display("FAIL sel0_nowrite: got %h expected %h", rd, e); end
  endtask

  task automatic test_wait_states();
    int lat;
    logic [31:0] rd, e;
    logic exp_ack;
    do_access(1, 1'b1, 32'hC, 4'hF, 32'h1234_5678, lat, rd);
    n_chk++;
    if (lat !== 4) begin n_err++; $display("FAIL ws_wr_lat: got %0d expected 4", lat); end
    exp_q.push_back(32'h1234_5678);
    exp_q.push_back(32'h1234_5678);
    dsel = 1;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'hC; sel = 4'hF;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      exp_ack = (i == 4) || (i == 9);
      e = 32'h0;
      if (exp_ack) e = exp_q.pop_front();
      n_chk++;
      if (ack_o !== exp_ack || dat_o !== e) begin
        n_err++;
        $display("FAIL ws_cycle%0d: got ack=%b dat=%h expected ack=%b dat=%h", i, ack_o, dat_o, exp_ack, e);
      end
    end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    logic exp_ack;
    exp_q.push_back(32'hA5A5_1234);
    exp_q.push_back(32'hA5A5_1234);
    exp_q.push_back(32'hA5A5_1234);
    dsel = 0;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h8; sel = 4'hF;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      exp_ack = (i % 2) == 1;
      e = 32'h0;
      if (exp_ack) e = exp_q.pop_front();
      n_chk++;
      if (ack_o !== exp_ack || dat_o !== e) begin
        n_err++;
        $display("FAIL b2b_cycle%0d: got ack=%b dat=%h expected ack=%b dat=%h", i, ack_o, dat_o, exp_ack, e);
      end
    end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
  endtask

  task automatic test_abort();
    int lat, acks;
    logic [31:0] rd, e;
    do_access(2, 1'b1, 32'h4, 4'hF, 32'h0BAD_F00D, lat, rd);
    n_chk++;
    if (lat !== 3) begin n_err++; $display("FAIL abort_pre_lat: got %0d expected 3", lat); end
    dsel = 2;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h4; sel = 4'hF; dat = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (ack_o) acks++;
    end
    n_chk++;
    if (acks !== 0) begin n_err++; $display("FAIL abort_ack: got %0d acks expected 0", acks); end
    exp_q.push_back(32'h0BAD_F00D);
    do_access(2, 1'b0, 32'h4, 4'hF, 32'h0, lat, rd);
    e = exp_q.pop_front();
    n_chk++;
    if (rd !== e || lat !== 3) begin
      n_err++;
      $display("FAIL abort_data: got %h lat %0d expected %h lat 3", rd, lat, e);
    end
  endtask

  task automatic test_range();
    int lat;
    logic [31:0] rd, e;
    do_access(0, 1'b1, 32'h0, 4'hF, 32'h0102_0304, lat, rd);
    do_access(0, 1'b1, 32'h40, 4'hF, 32'hDEAD_BEEF, lat, rd);
    n_chk++;
    if (lat !== 1) begin n_err++; $display("FAIL range_wr_lat: got %0d expected 1", lat); end
`ifdef WB_RAM_RANGE_CHECK_EN
    exp_q.push_back(32'h0000_0000);
    exp_q.push_back(32'h0102_0304);
`else
    exp_q.push_back(32'hDEAD_BEEF);
    exp_q.push_back(32'hDEAD_BEEF);
`endif
    do_access(0, 1'b0, 32'h40, 4'hF, 32'h0, lat, rd);
    e = exp_q.pop_front();
    n_chk++;
    if (rd !== e) begin n_err++; $display("FAIL range_rd40: got %h expected %h", rd, e); end
    do_access(0, 1'b0, 32'h0, 4'hF, 32'h0, lat, rd);
    e = exp_q.pop_front();
    n_chk++;
    if (rd !== e) begin n_err++; $display("FAIL range_rd0: got %h expected %h", rd, e); end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [31:0] rd, e;
    do_access(1, 1'b1, 32'h14, 4'hF, 32'h1357_9BDF, lat, rd);
    dsel = 1;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h14; sel = 4'hF; dat = 32'h55AA_55AA;
    @(posedge clk); #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({ack_o, dat_o} !== 33'h0) begin
      n_err++;
      $display("FAIL rst_busy_out: got ack=%b dat=%h expected ack=0 dat=0", ack_o, dat_o);
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    exp_q.push_back(32'h1357_9BDF);
    do_access(1, 1'b0, 32'h14, 4'hF, 32'h0, lat, rd);
    e = exp_q.pop_front();
    n_chk++;
    if (rd !== e || lat !== 4) begin
      n_err++;
      $display("FAIL rst_busy_after: got %h lat %0d expected %h lat 4", rd, lat, e);
    end
    // reset arriving on the same edge as a write commit
    do_access(0, 1'b1, 32'h1C, 4'hF, 32'h2468_ACE0, lat, rd);
    dsel = 0;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h1C; sel = 4'hF; dat = 32'hFFFF_0000;
    @(posedge clk); #1;
    rstn = 1'b0;
    @(negedge clk);
    n_chk++;
    if (ack_o !== 1'b1) begin n_err++; $display("FAIL rst_ack_seen: got %b expected 1", ack_o); end
    @(posedge clk); #1;
    rstn = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    exp_q.push_back(32'h2468_ACE0);
    do_access(0, 1'b0, 32'h1C, 4'hF, 32'h0, lat, rd);
    e = exp_q.pop_front();
    n_chk++;
    if (rd !== e || lat !== 1) begin
      n_err++;
      $display("FAIL rst_ack_nowrite: got %h lat %0d expected %h lat 1", rd, lat, e);
    end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_byte_lane();
    test_wait_states();
    test_back_to_back();
    test_abort();
    test_range();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
